// File: rtl/calc2_pkg.sv
// Shared types and constants for the calc2 requester-side logic.
package calc2_pkg;

  localparam int CALC2_TAG_W       = 2;
  localparam int CALC2_NUM_TAGS    = 4;
  localparam int CALC2_CMD_W       = 4;
  localparam int CALC2_DATA_W      = 32;
  localparam int CALC2_TIMEOUT_CYC = 64;

  typedef logic [CALC2_TAG_W-1:0]  tag_t;
  typedef logic [CALC2_CMD_W-1:0]  cmd_t;
  typedef logic [CALC2_DATA_W-1:0] data_t;
  typedef logic [1:0]              resp_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_ADD = 4'd1;
  localparam cmd_t CMD_SUB = 4'd2;
  localparam cmd_t CMD_SHL = 4'd5;
  localparam cmd_t CMD_SHR = 4'd6;

  localparam resp_t RESP_NONE    = 2'd0;
  localparam resp_t RESP_OK      = 2'd1;
  localparam resp_t RESP_OVF     = 2'd2;
  localparam resp_t RESP_INVALID = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_DATA2
  } fsm_state_e;

endpackage

// File: rtl/calc2_tag_pool.sv
// Tag bookkeeping: busy vector, lowest-free pick, per-tag age timers and
// busy popcount. Free/busy decisions all use the registered busy vector.
module calc2_tag_pool
  import calc2_pkg::*;
#(
  parameter int NUM_TAGS    = CALC2_NUM_TAGS,
  parameter int TAG_W       = CALC2_TAG_W,
  parameter int TIMEOUT_CYC = CALC2_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc,
  input  logic                clr,
  input  logic [TAG_W-1:0]    clr_tag,
  output logic [NUM_TAGS-1:0] busy,
  output logic                any_free,
  output logic [TAG_W-1:0]    free_tag,
  output logic [NUM_TAGS-1:0] expire,
  output logic [TAG_W:0]      count
);

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  always_comb begin
    any_free = 1'b0;
    free_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free = 1'b1;
        free_tag = TAG_W'(i);
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      count = count + {{TAG_W{1'b0}}, busy[i]};
    end
  end

  for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
    logic             busy_q;
    logic [TMR_W-1:0] tmr_q;
    logic             set_g;
    logic             rsp_g;

    assign set_g     = alloc && (free_tag == TAG_W'(g));
    assign rsp_g     = clr && (clr_tag == TAG_W'(g));
    // A response landing on the expiry cycle retires the tag normally.
    assign expire[g] = busy_q && (tmr_q == TMR_LAST) && !rsp_g;
    assign busy[g]   = busy_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        busy_q <= 1'b0;
        tmr_q  <= '0;
      end else if (set_g) begin
        busy_q <= 1'b1;
        tmr_q  <= '0;
      end else if (rsp_g || expire[g]) begin
        busy_q <= 1'b0;
        tmr_q  <= '0;
      end else if (busy_q) begin
        tmr_q  <= tmr_q + TMR_W'(1);
      end
    end
  end

endmodule

// File: rtl/calc2_port_issuer.sv
// Issues whole operations onto one calc2 requester port as cmd/data beat
// pairs, retires tags from the port's responses and flags protocol errors.
module calc2_port_issuer
  import calc2_pkg::*;
#(
  parameter int NUM_TAGS    = CALC2_NUM_TAGS,
  parameter int TAG_W       = CALC2_TAG_W,
  parameter int CMD_W       = CALC2_CMD_W,
  parameter int DATA_W      = CALC2_DATA_W,
  parameter int TIMEOUT_CYC = CALC2_TIMEOUT_CYC
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [CMD_W-1:0]  op_cmd,
  input  logic [DATA_W-1:0] op_data1,
  input  logic [DATA_W-1:0] op_data2,
  output logic [CMD_W-1:0]  req_cmd_in,
  output logic [DATA_W-1:0] req_data_in,
  output logic [TAG_W-1:0]  req_tag_in,
  input  logic [1:0]        out_resp,
  input  logic [DATA_W-1:0] out_data,
  input  logic [TAG_W-1:0]  out_tag,
  output logic              cpl_valid,
  output logic [1:0]        cpl_resp,
  output logic [DATA_W-1:0] cpl_data,
  output logic [TAG_W-1:0]  cpl_tag,
  output logic [TAG_W:0]    outstanding,
  output logic              err_unexp_tag,
  output logic              err_timeout,
  output logic [TAG_W-1:0]  err_tag
);

  fsm_state_e state_q, state_d;

  logic [DATA_W-1:0]   data2_q;
  logic [CMD_W-1:0]    req_cmd_d;
  logic [DATA_W-1:0]   req_data_d;
  logic [TAG_W-1:0]    req_tag_d;
  logic [NUM_TAGS-1:0] busy;
  logic [NUM_TAGS-1:0] expire;
  logic [TAG_W-1:0]    free_tag;
  logic [TAG_W-1:0]    to_tag;
  logic                any_free;
  logic                hs, alloc;
  logic                rsp_vld, rsp_hit, rsp_unexp;
  logic                to_any, err_seen;

  assign op_ready  = (state_q == ST_IDLE) && any_free;
  assign hs        = op_valid && op_ready;
  assign alloc     = hs && (op_cmd != '0);
  assign rsp_vld   = (out_resp != RESP_NONE);
  assign rsp_hit   = rsp_vld && busy[out_tag];
  assign rsp_unexp = rsp_vld && !busy[out_tag];
  assign err_seen  = err_unexp_tag || err_timeout;

  calc2_tag_pool #(
    .NUM_TAGS    (NUM_TAGS),
    .TAG_W       (TAG_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_pool (
    .clk      (c_clk),
    .reset    (reset),
    .alloc    (alloc),
    .clr      (rsp_hit),
    .clr_tag  (out_tag),
    .busy     (busy),
    .any_free (any_free),
    .free_tag (free_tag),
    .expire   (expire),
    .count    (outstanding)
  );

  // Lowest expiring tag is the one reported when several age out together.
  always_comb begin
    to_any = |expire;
    to_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (expire[i]) to_tag = TAG_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    req_cmd_d  = '0;
    req_data_d = '0;
    req_tag_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (alloc) begin
          state_d    = ST_DATA2;
          req_cmd_d  = op_cmd;
          req_data_d = op_data1;
          req_tag_d  = free_tag;
        end
      end
      ST_DATA2: begin
        state_d    = ST_IDLE;
        req_data_d = data2_q;
        req_tag_d  = req_tag_in;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      data2_q     <= '0;
      req_cmd_in  <= '0;
      req_data_in <= '0;
      req_tag_in  <= '0;
    end else begin
      state_q     <= state_d;
      req_cmd_in  <= req_cmd_d;
      req_data_in <= req_data_d;
      req_tag_in  <= req_tag_d;
      if (alloc) data2_q <= op_data2;
    end
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      cpl_valid <= 1'b0;
      cpl_resp  <= '0;
      cpl_data  <= '0;
      cpl_tag   <= '0;
    end else begin
      cpl_valid <= rsp_hit;
      if (rsp_hit) begin
        cpl_resp <= out_resp;
        cpl_data <= out_data;
        cpl_tag  <= out_tag;
      end
    end
  end

  // err_tag records only the first error; an unexpected tag beats a timeout.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      err_unexp_tag <= 1'b0;
      err_timeout   <= 1'b0;
      err_tag       <= '0;
    end else begin
      if (rsp_unexp) err_unexp_tag <= 1'b1;
      if (to_any)    err_timeout   <= 1'b1;
      if (!err_seen) begin
        if (rsp_unexp)   err_tag <= out_tag;
        else if (to_any) err_tag <= to_tag;
      end
    end
  end

endmodule

// File: doc/calc2_port_issuer.md
Name: calc2_port_issuer

Overview:
- Request-side stage that sits directly upstream of one calc2_top requester port; four instances feed ports 1-4.
- Accepts whole operations (cmd + two operands) over a valid/ready interface and allocates a free 2-bit tag.
- Serialises each operation onto the port's two-cycle cmd/data protocol.
- Retires tags from that port's out_resp/out_tag/out_data. Forwards completions and flags protocol errors (unexpected tag, timeout).

Parameters:
- NUM_TAGS, 4, outstanding tags per port; equals 2**TAG_W.
- TAG_W, 2, tag width.
- CMD_W, 4, command width.
- DATA_W, 32, operand/result width.
- TIMEOUT_CYC, 64, cycles a tag may stay busy before being declared lost.

Ports:
- c_clk  in  1  sole clock.
- reset  in  1  synchronous, active-low reset.
- op_valid  in  1  operation offered.
- op_ready  out  1  operation accepted when high with op_valid.
- op_cmd  in  CMD_W  command.
- op_data1  in  DATA_W  first operand.
- op_data2  in  DATA_W  second operand.
- req_cmd_in  out  CMD_W  to calc2 reqN_cmd_in.
- req_data_in  out  DATA_W  to calc2 reqN_data_in.
- req_tag_in  out  TAG_W  to calc2 reqN_tag_in.
- out_resp  in  2  from calc2 out_respN.
- out_data  in  DATA_W  from calc2 out_dataN.
- out_tag  in  TAG_W  from calc2 out_tagN.
- cpl_valid  out  1  one-cycle completion pulse.
- cpl_resp  out  2  completed response code.
- cpl_data  out  DATA_W  completed result.
- cpl_tag  out  TAG_W  completed tag.
- outstanding  out  TAG_W+1  count of busy tags.
- err_unexp_tag  out  1  sticky: response on a non-busy tag.
- err_timeout  out  1  sticky: a tag exceeded TIMEOUT_CYC.
- err_tag  out  TAG_W  tag of the first error captured.

Behaviour:
- Reset (reset==0 at a c_clk edge):
  - All outputs go to 0, busy vector and timers clear, FSM returns to IDLE.
  - Reset mid-operation abandons the operation; the DUT is reset in the same cycle.
- FSM has two states, IDLE and DATA2.
  - op_ready = (state==IDLE) && (at least one tag free).
  - IDLE, handshake with op_cmd!=0: on the next cycle drive req_cmd_in=op_cmd, req_data_in=op_data1, req_tag_in=lowest-index free tag. Mark the tag busy, zero its timer, go to DATA2.
  - IDLE, handshake with op_cmd==0: consumed; no tag allocated, nothing driven, stay in IDLE.
  - DATA2: drive req_cmd_in=0, req_data_in=op_data2 (registered at acceptance), req_tag_in held. Return to IDLE.
  - IDLE with no handshake: req_cmd_in=0, req_data_in=0, req_tag_in=0.
  - Maximum issue rate is one operation per 2 cycles. All req_* outputs are registered.
- Completion: sampled when out_resp!=0.
  - Tag busy: clear busy; next cycle cpl_valid=1 with out_resp/out_data/out_tag registered.
  - Tag not busy: no completion; set err_unexp_tag. If no error has been captured yet, load err_tag.
  - All out_resp codes (01, 10, 11) retire the tag.
- Timeout: each busy tag's timer increments every cycle.
  - At TIMEOUT_CYC-1 the tag is freed with no completion, err_timeout is set, and err_tag is loaded if no error has been captured yet.
- Simultaneous events:
  - Response and timeout on the same tag in the same cycle: the response wins, so no timeout is raised.
  - A tag freed in cycle N is not eligible for allocation until cycle N+1; allocation uses the registered busy vector.
  - Two error sources in the same cycle: err_unexp_tag wins the err_tag capture.
- outstanding equals the popcount of the registered busy vector.
- Sticky error flags and err_tag clear only on reset.

Decomposition:
- Shared package calc2_pkg holds:
  - command constants (CMD_NOP=0, ADD=1, SUB=2, SHL=5, SHR=6);
  - response constants (RESP_NONE=0, OK=1, OVF=2, INVALID=3);
  - tag_t / cmd_t / data_t typedefs;
  - the fsm state enum.
- One sub-module, calc2_tag_pool: busy vector, lowest-free priority encoder, per-tag timers, popcount.

Test Plan:
- Reset low for 2 cycles, then op ADD, 5, 7 -> req cycle 1 = cmd 1/data 5/tag 0, cycle 2 = cmd 0/data 7/tag 0. Response 01/12/tag 0 -> cpl_valid with data 12, tag 0, outstanding back to 0.
- Issue 4 ops with no responses -> tags 0,1,2,3 in order, op_ready=0, outstanding=4. Respond tag 2 -> op_ready high next cycle and the next op gets tag 2.
- Response 01 on idle tag 3 after reset -> err_unexp_tag=1, err_tag=3, cpl_valid stays 0.
- Issue 1 op and never respond -> after TIMEOUT_CYC cycles err_timeout=1, err_tag=0, outstanding=0.
- Response on a tag in the same cycle its timer expires -> cpl_valid=1, err_timeout stays 0.
- Assert reset while in DATA2 -> next cycle all req_* = 0, outstanding=0, errors cleared, state IDLE.
